// File: rtl/imm_extend_pipe.sv
// Immediate extender (sign / zero / upper / sign-shift-2) feeding a 2-entry FIFO
// with valid/ready handshakes. Define IMM_EXT_CNT_EN to add the Xfer_Count port.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [IN_W-1:0]  In_Imm,
  input  logic [1:0]       In_Mode,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [OUT_W-1:0] Out_Data
`ifdef IMM_EXT_CNT_EN
  ,
  output logic [15:0]      Xfer_Count
`endif
);

  localparam int EXT_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SEXT     = 2'b00;
  localparam logic [1:0] MODE_ZEXT     = 2'b01;
  localparam logic [1:0] MODE_UPPER    = 2'b10;

  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [1:0]      mode);
    logic signed [OUT_W-1:0] sext;
    logic        [OUT_W-1:0] res;
    sext = {{EXT_W{imm[IN_W-1]}}, imm};
    case (mode)
      MODE_SEXT:  res = sext;
      MODE_ZEXT:  res = {{EXT_W{1'b0}}, imm};
      MODE_UPPER: res = {imm, {EXT_W{1'b0}}};
      default:    res = sext <<< 2;
    endcase
    return res;
  endfunction

  logic [OUT_W-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;
  logic [OUT_W-1:0] ext_p0;

  // Handshake decode: ready comes from the registered count only
  assign In_Ready  = (count_q < 2'd2);
  assign push      = In_Valid && In_Ready;
  assign pop       = out_valid_q && Out_Ready;
  assign ext_p0    = extend_imm(In_Imm, In_Mode);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is cleared on reset so Out_Data reads zero until the first word lands
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= ext_p0;
    end
  end

  assign Out_Valid = out_valid_q;
  assign Out_Data  = mem_q[rd_ptr_q];

`ifdef IMM_EXT_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  assign xfer_cnt_d = xfer_cnt_q + 16'd1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)   xfer_cnt_q <= 16'd0;
    else if (pop) xfer_cnt_q <= xfer_cnt_d;
  end

  assign Xfer_Count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: randomized and directed traffic checked
// against an arithmetic reference model; counter wrap tested when IMM_EXT_CNT_EN is set.
module tb_imm_extend_pipe;

  logic        Clk;
  logic        Rst_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] In_Imm;
  logic [1:0]  In_Mode;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Data;
`ifdef IMM_EXT_CNT_EN
  logic [15:0] Xfer_Count;
`endif

  logic        s_valid, s_ready, s_ovalid, s_oready;
  logic [7:0]  s_imm;
  logic [1:0]  s_mode;
  logic [15:0] s_data;
`ifdef IMM_EXT_CNT_EN
  logic [15:0] s_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];
  int          exp_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  imm_extend_pipe dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Imm(In_Imm), .In_Mode(In_Mode), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Data(Out_Data)
`ifdef IMM_EXT_CNT_EN
    , .Xfer_Count(Xfer_Count)
`endif
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(s_valid), .In_Ready(s_ready),
    .In_Imm(s_imm), .In_Mode(s_mode), .Out_Valid(s_ovalid),
    .Out_Ready(s_oready), .Out_Data(s_data)
`ifdef IMM_EXT_CNT_EN
    , .Xfer_Count(s_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: interpret the immediate as a number and apply the mode's arithmetic
  function automatic logic [31:0] model(input int inw, input int outw,
                                        input longint imm, input logic [1:0] mode);
    longint sv;
    longint mask;
    longint r;
    mask = (longint'(1) <<< outw) - 1;
    sv   = (imm >= (longint'(1) <<< (inw - 1))) ? imm - (longint'(1) <<< inw) : imm;
    case (mode)
      2'd0:    r = sv;
      2'd1:    r = imm;
      2'd2:    r = imm * (longint'(1) <<< (outw - inw));
      default: r = sv * 4;
    endcase
    return 32'(r & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; inputs set just after the rising edge
  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic ordy);
    In_Valid  = v;
    In_Imm    = imm;
    In_Mode   = mode;
    Out_Ready = ordy;
    @(negedge Clk);
    if (In_Valid && In_Ready) exp_q.push_back(model(16, 32, longint'(In_Imm), In_Mode));
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compares every output transfer with the scoreboard head
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_stall = 1'b0;
      exp_cnt    = 0;
    end else begin
      if (prev_stall && Out_Valid) check("stall_stable", Out_Data, prev_data);
`ifdef IMM_EXT_CNT_EN
      check("xfer_count", 32'(Xfer_Count), 32'(exp_cnt % 65536));
`endif
      if (Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got 0x%08h expected no word", Out_Data);
        end else begin
          check("fifo_data", Out_Data, exp_q.pop_front());
        end
        exp_cnt++;
      end
      prev_stall = Out_Valid && !Out_Ready;
      prev_data  = Out_Data;
    end
  end

  initial begin
    Rst_n = 1'b0; In_Valid = 1'b0; In_Imm = '0; In_Mode = '0; Out_Ready = 1'b0;
    s_valid = 1'b0; s_imm = '0; s_mode = '0; s_oready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_in_ready", 32'(In_Ready), 32'd1);
    check("rst_out_data", Out_Data, 32'd0);
    Rst_n = 1'b1;

    // Mode table with 0x8001, consecutive push+pop each cycle
    drive(1'b1, 16'h8001, 2'd0, 1'b1);
    check("mode00", Out_Data, 32'hFFFF8001);
    drive(1'b1, 16'h8001, 2'd1, 1'b1);
    check("mode01", Out_Data, 32'h00008001);
    drive(1'b1, 16'h8001, 2'd2, 1'b1);
    check("mode10", Out_Data, 32'h80010000);
    drive(1'b1, 16'h8001, 2'd3, 1'b1);
    check("mode11", Out_Data, 32'hFFFE0004);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    check("drained_valid", 32'(Out_Valid), 32'd0);

    // Simultaneous push and pop at count 1
    drive(1'b1, 16'h1234, 2'd1, 1'b0);
    drive(1'b1, 16'h0004, 2'd0, 1'b1);
    check("simul_valid", 32'(Out_Valid), 32'd1);
    check("simul_ready", 32'(In_Ready), 32'd1);
    check("simul_data", Out_Data, 32'h00000004);
    drive(1'b0, 16'h0, 2'd0, 1'b1);

    // Backpressure with three words offered
    drive(1'b1, 16'h00A5, 2'd0, 1'b0);
    check("bp_ready1", 32'(In_Ready), 32'd1);
    drive(1'b1, 16'hFF00, 2'd3, 1'b0);
    check("bp_ready2", 32'(In_Ready), 32'd0);
    drive(1'b1, 16'h7FFF, 2'd2, 1'b0);
    check("bp_head", Out_Data, 32'h000000A5);
    drive(1'b1, 16'h7FFF, 2'd2, 1'b0);
    check("bp_head_hold", Out_Data, 32'h000000A5);
    drive(1'b1, 16'h7FFF, 2'd2, 1'b1);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    repeat (3) drive(1'b0, 16'h0, 2'd0, 1'b1);

    // Reset mid-stream with two words buffered
    drive(1'b1, 16'h1111, 2'd1, 1'b0);
    drive(1'b1, 16'h2222, 2'd1, 1'b0);
    In_Valid = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(Out_Valid), 32'd0);
    check("midrst_ready", 32'(In_Ready), 32'd1);
    check("midrst_data", Out_Data, 32'd0);
    exp_q.delete();
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    drive(1'b1, 16'h0333, 2'd2, 1'b1);
    check("post_rst_first", Out_Data, 32'h03330000);
    repeat (3) drive(1'b0, 16'h0, 2'd0, 1'b1);

    // Narrow instance
    s_valid = 1'b1; s_imm = 8'h80; s_mode = 2'd0;
    @(posedge Clk); #1;
    check("w8_mode00", 32'(s_data), 32'h0000FF80);
    s_mode = 2'd2;
    @(posedge Clk); #1;
    check("w8_mode10", 32'(s_data), 32'h00008000);
    s_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(0, 9) < 7), 16'($urandom), 2'($urandom), ($urandom_range(0, 9) < 6));
    repeat (4) drive(1'b0, 16'h0, 2'd0, 1'b1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef IMM_EXT_CNT_EN
    Rst_n = 1'b0;
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    for (int i = 0; i < 65537; i++)
      drive(1'b1, 16'($urandom), 2'($urandom), 1'b1);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    check("cnt_wrap_final", 32'(Xfer_Count), 32'h00000001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter IN_W, default 16, SHALL set the immediate input width.
REQ-003 Parameter OUT_W, default 32, SHALL set the extended output width; it SHALL satisfy OUT_W >= IN_W+2.
REQ-004 Clk  input  1  SHALL be the sole clock; all state SHALL update on the rising edge.
REQ-005 Rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 In_Valid  input  1  SHALL mark the input word as valid.
REQ-007 In_Ready  output  1  SHALL indicate that the block can accept an input word.
REQ-008 In_Imm  input  IN_W  SHALL carry the immediate field.
REQ-009 In_Mode  input  2  SHALL select the extension: 00 sign, 01 zero, 10 upper, 11 sign-shift-2.
REQ-010 Out_Valid  output  1  SHALL mark the output word as valid.
REQ-011 Out_Ready  input  1  SHALL indicate that the consumer accepts the output word.
REQ-012 Out_Data  output  OUT_W  SHALL carry the extended result.
REQ-013 Xfer_Count  output  16  SHALL count completed output transfers; this port SHALL exist only when IMM_EXT_CNT_EN is defined.

Function
REQ-014 An input transfer SHALL occur on a rising edge where In_Valid && In_Ready; an output transfer SHALL occur on a rising edge where Out_Valid && Out_Ready.
REQ-015 Mode 00 SHALL produce Out_Data = In_Imm with bit IN_W-1 replicated into bits OUT_W-1..IN_W.
REQ-016 Mode 01 SHALL produce Out_Data = In_Imm with bits OUT_W-1..IN_W equal to zero.
REQ-017 Mode 10 SHALL produce Out_Data = In_Imm placed in bits OUT_W-1..OUT_W-IN_W, with the lower bits zero.
REQ-018 Mode 11 SHALL produce Out_Data = (the mode-00 result) shifted left by 2, with bits 1..0 zero and the top 2 bits discarded.
REQ-019 The result SHALL be computed at the time of the input transfer and stored in a 2-entry FIFO; In_Imm and In_Mode SHALL NOT be held by the producer after the transfer.
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on Out_Valid/Out_Data after edge N when the FIFO was empty.
REQ-021 Out_Valid SHALL be 1 iff the FIFO count is greater than 0; Out_Data SHALL present the head entry.
REQ-022 In_Ready SHALL be 1 iff the registered count is less than 2; In_Ready SHALL NOT depend combinationally on Out_Ready.
REQ-023 Out_Data and Out_Valid SHALL be driven from registers only (no combinational path from the input side).
REQ-024 Count 0 with a push SHALL become count 1; count 1 with both a push and a pop SHALL stay 1 and present the new word after the edge.
REQ-025 Count 2 with a pop SHALL become count 1; a push at count 2 SHALL be impossible because In_Ready is 0.
REQ-026 FIFO order SHALL be strictly first-in-first-out; no word SHALL be dropped or duplicated.
REQ-027 Out_Data SHALL remain stable while Out_Valid && !Out_Ready.
REQ-028 The FIFO pointers SHALL wrap from 1 to 0.

Reset
REQ-029 Rst_n low SHALL asynchronously clear the count, the pointers, and Out_Valid to 0.
REQ-030 Out_Data SHALL reset to 0, In_Ready SHALL reset to 1, and Xfer_Count (when present) SHALL reset to 0.
REQ-031 A reset asserted mid-operation SHALL discard all buffered words.
REQ-032 After Rst_n deasserts, the first rising edge SHALL accept an input word normally.

Configuration
REQ-033 With IMM_EXT_CNT_EN defined, Xfer_Count SHALL increment by 1 on each output transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-034 Without IMM_EXT_CNT_EN, the Xfer_Count port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Reset: hold Rst_n low mid-stream with 2 words buffered -> Out_Valid=0, In_Ready=1, Out_Data=0, and no stale word after release.
REQ-036 Modes (defaults): In_Imm=0x8001 gives mode 00 -> 0xFFFF8001; mode 01 -> 0x00008001; mode 10 -> 0x80010000; mode 11 -> 0xFFFE0004.
REQ-037 Backpressure: Out_Ready=0 while pushing 3 words -> In_Ready=0 after the 2nd word; releasing Out_Ready drains the words in order with Out_Data stable while stalled.
REQ-038 Simultaneous events: at count 1, push 0x0004 in mode 00 while popping -> count stays 1 and Out_Data=0x00000004 after the edge.
REQ-039 Parameters IN_W=8, OUT_W=16: In_Imm=0x80 gives mode 00 -> 0xFF80 and mode 10 -> 0x8000.
REQ-040 With IMM_EXT_CNT_EN: preload the counter to 0xFFFE via 2 fewer than 65536 transfers, then perform 3 more transfers -> Xfer_Count reads 0xFFFF, 0x0000, 0x0001.
